// File: rtl/layer_mixer_if.sv
// Pixel, palette-write and composed-colour signals of the layer mixer.
// master drives pixels and palette writes; slave is the mixer.
interface layer_mixer_if #(
  parameter int unsigned NUM_LAYERS = 8,
  parameter int unsigned IDX_W      = 3,
  parameter int unsigned RGB_W      = 4
);
  logic                        pix_valid;
  logic [NUM_LAYERS*IDX_W-1:0] layer_idx;
  logic                        frame_start;
  logic [NUM_LAYERS-1:0]       layer_en;
  logic [NUM_LAYERS-1:0]       flash_mask;
  logic                        pal_we;
  logic [IDX_W-1:0]            pal_addr;
  logic [RGB_W-1:0]            pal_data;
  logic [RGB_W-1:0]            rgb;
  logic                        rgb_valid;
  logic [3:0]                  hit_layer;

  modport master (
    output pix_valid, layer_idx, frame_start, layer_en, flash_mask,
    output pal_we, pal_addr, pal_data,
    input  rgb, rgb_valid, hit_layer
  );

  modport slave (
    input  pix_valid, layer_idx, frame_start, layer_en, flash_mask,
    input  pal_we, pal_addr, pal_data,
    output rgb, rgb_valid, hit_layer
  );
endinterface

// File: rtl/layer_mixer.sv
// Two-stage priority layer mixer with a register palette.
// Define MIXER_FLASH_EN to add frame-counted flash blanking of masked layers.
module layer_mixer #(
  parameter int unsigned NUM_LAYERS   = 8,
  parameter int unsigned IDX_W        = 3,
  parameter int unsigned RGB_W        = 4,
  parameter int unsigned FLASH_FRAMES = 16
) (
  input logic          clk,
  input logic          rst_n,
  layer_mixer_if.slave mix
);
  localparam int unsigned PalDepth = 1 << IDX_W;

  function automatic logic [RGB_W-1:0] pal_reset(input int unsigned i);
    logic [3:0] v;
    case (i)
      0:       v = 4'b0000;
      1:       v = 4'b0011;
      2:       v = 4'b0001;
      3:       v = 4'b0111;
      4:       v = 4'b0100;
      5:       v = 4'b1101;
      6:       v = 4'b0110;
      7:       v = 4'b1011;
      default: v = 4'b0000;
    endcase
    return RGB_W'(v);
  endfunction

  logic [NUM_LAYERS-1:0] blank;

`ifdef MIXER_FLASH_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       flash_phase_q, flash_phase_d;

  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    flash_phase_d = flash_phase_q;
    if (mix.frame_start) begin
      if (frame_cnt_q == 8'(FLASH_FRAMES - 1)) begin
        frame_cnt_d   = '0;
        flash_phase_d = ~flash_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q   <= '0;
      flash_phase_q <= 1'b0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      flash_phase_q <= flash_phase_d;
    end
  end

  // Registered phase: a frame_start only affects pixels from the next cycle on.
  assign blank = flash_phase_q ? mix.flash_mask : '0;
`else
  logic unused_flash;
  assign unused_flash = ^{mix.flash_mask, mix.frame_start, 8'(FLASH_FRAMES)};
  assign blank        = '0;
`endif

  // Stage 1: priority pick, layer 0 first.
  logic             win_found;
  logic [IDX_W-1:0] s1_idx_d, s1_idx_q;
  logic [3:0]       s1_hit_d, s1_hit_q;
  logic             s1_valid_q;

  always_comb begin
    win_found = 1'b0;
    s1_idx_d  = '0;
    s1_hit_d  = 4'hf;
    for (int unsigned k = 0; k < NUM_LAYERS; k++) begin
      if (!win_found && mix.layer_en[k] && !blank[k] &&
          (mix.layer_idx[k*IDX_W +: IDX_W] != '0)) begin
        win_found = 1'b1;
        s1_idx_d  = mix.layer_idx[k*IDX_W +: IDX_W];
        s1_hit_d  = 4'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      s1_hit_q   <= 4'hf;
    end else begin
      s1_valid_q <= mix.pix_valid;
      if (mix.pix_valid) begin
        s1_idx_q <= s1_idx_d;
        s1_hit_q <= s1_hit_d;
      end
    end
  end

  // Stage 2 reads the palette before any same-edge write lands.
  logic [RGB_W-1:0] pal_q [PalDepth];
  logic [RGB_W-1:0] rgb_q;
  logic [3:0]       hit_q;
  logic             rgb_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < PalDepth; i++) begin
        pal_q[i] <= pal_reset(i);
      end
    end else if (mix.pal_we) begin
      pal_q[mix.pal_addr] <= mix.pal_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_valid_q <= 1'b0;
      rgb_q       <= '0;
      hit_q       <= 4'hf;
    end else begin
      rgb_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        rgb_q <= pal_q[s1_idx_q];
        hit_q <= s1_hit_q;
      end
    end
  end

  assign mix.rgb       = rgb_q;
  assign mix.rgb_valid = rgb_valid_q;
  assign mix.hit_layer = hit_q;
endmodule

// File: tb/tb_layer_mixer.sv
// Directed bench for layer_mixer: queue-based reference model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_layer_mixer;
  localparam int unsigned NL = 8;
  localparam int unsigned IW = 3;
  localparam int unsigned RW = 4;
  localparam int unsigned FF = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  layer_mixer_if #(.NUM_LAYERS(NL), .IDX_W(IW), .RGB_W(RW)) mix ();

  layer_mixer #(
    .NUM_LAYERS  (NL),
    .IDX_W       (IW),
    .RGB_W       (RW),
    .FLASH_FRAMES(FF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mix  (mix)
  );

  logic [IW-1:0] lv [NL];
  always_comb begin
    mix.layer_idx = '0;
    for (int k = 0; k < int'(NL); k++) mix.layer_idx[k*IW +: IW] = lv[k];
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: pending pixels carry the cycle they must appear on.
  typedef struct {
    int unsigned   due;
    logic [IW-1:0] idx;
    logic [3:0]    hit;
  } pend_t;

  localparam logic [3:0] DEF_PAL [8] = '{4'b0000, 4'b0011, 4'b0001, 4'b0111,
                                         4'b0100, 4'b1101, 4'b0110, 4'b1011};
  pend_t         pq [$];
  logic [RW-1:0] pal_m [1 << IW];
  int unsigned   cyc;
  int unsigned   nfs;
  logic          exp_valid;
  logic [RW-1:0] exp_rgb;
  logic [3:0]    exp_hit;

  function automatic pend_t pick(input int unsigned due);
    pend_t p;
    logic  phase;
    p.due = due;
    p.idx = '0;
    p.hit = 4'hf;
    phase = ((nfs / FF) % 2) == 1;
`ifndef MIXER_FLASH_EN
    phase = 1'b0;
`endif
    for (int k = int'(NL) - 1; k >= 0; k--) begin
      if (mix.layer_en[k] && lv[k] != 0 && !(phase && mix.flash_mask[k])) begin
        p.idx = lv[k];
        p.hit = 4'(k);
      end
    end
    return p;
  endfunction

  task automatic model_step();
    pend_t p;
    if (!rst_n) begin
      pq.delete();
      for (int i = 0; i < (1 << IW); i++) pal_m[i] = RW'(DEF_PAL[i]);
      cyc       = 0;
      nfs       = 0;
      exp_valid = 1'b0;
      exp_rgb   = '0;
      exp_hit   = 4'hf;
    end else begin
      cyc++;
      exp_valid = 1'b0;
      if (pq.size() > 0 && pq[0].due == cyc) begin
        p         = pq.pop_front();
        exp_valid = 1'b1;
        exp_rgb   = pal_m[p.idx];
        exp_hit   = p.hit;
      end
      if (mix.pix_valid) pq.push_back(pick(cyc + 1));
      if (mix.pal_we) pal_m[mix.pal_addr] = mix.pal_data;
      if (mix.frame_start) nfs++;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    check("cmp.rgb_valid", 32'(mix.rgb_valid), 32'(exp_valid));
    check("cmp.rgb", 32'(mix.rgb), 32'(exp_rgb));
    check("cmp.hit_layer", 32'(mix.hit_layer), 32'(exp_hit));
  end

  task automatic pixel(input string nm, input logic fs, input logic [3:0] r,
                       input logic [3:0] h);
    @(negedge clk);
    mix.pix_valid   = 1'b1;
    mix.frame_start = fs;
    @(negedge clk);
    mix.pix_valid   = 1'b0;
    mix.frame_start = 1'b0;
    @(negedge clk);
    check({nm, ".valid"}, 32'(mix.rgb_valid), 32'd1);
    check({nm, ".rgb"}, 32'(mix.rgb), 32'(r));
    check({nm, ".hit"}, 32'(mix.hit_layer), 32'(h));
  endtask

  task automatic pal_write(input logic [IW-1:0] a, input logic [RW-1:0] d);
    @(negedge clk);
    mix.pal_we   = 1'b1;
    mix.pal_addr = a;
    mix.pal_data = d;
    @(negedge clk);
    mix.pal_we = 1'b0;
  endtask

  logic [IW-1:0] bb_lv  [4][NL];
  logic [3:0]    bb_rgb [4];
  logic [3:0]    bb_hit [4];
  logic [3:0]    co_rgb [4];
  logic [3:0]    co_hit [4];
  logic [3:0]    af_rgb [4];
  logic [3:0]    af_hit [4];

  initial begin
    mix.pix_valid   = 1'b0;
    mix.frame_start = 1'b0;
    mix.layer_en    = '1;
    mix.flash_mask  = '0;
    mix.pal_we      = 1'b0;
    mix.pal_addr    = '0;
    mix.pal_data    = '0;
    lv = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};

    bb_lv[0] = '{3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    bb_lv[1] = '{3'd0, 3'd0, 3'd0, 3'd6, 3'd2, 3'd0, 3'd0, 3'd0};
    bb_lv[2] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7};
    bb_lv[3] = '{3'd5, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    bb_rgb   = '{4'b0011, 4'b0110, 4'b1011, 4'b1101};
    bb_hit   = '{4'd0, 4'd3, 4'd7, 4'd0};
`ifdef MIXER_FLASH_EN
    co_rgb = '{4'b1101, 4'b1101, 4'b0011, 4'b0011};
    co_hit = '{4'd1, 4'd1, 4'd3, 4'd3};
    af_rgb = '{4'b1101, 4'b0011, 4'b0011, 4'b1101};
    af_hit = '{4'd1, 4'd3, 4'd3, 4'd1};
`else
    co_rgb = '{4'b1101, 4'b1101, 4'b1101, 4'b1101};
    co_hit = '{4'd1, 4'd1, 4'd1, 4'd1};
    af_rgb = '{4'b1101, 4'b1101, 4'b1101, 4'b1101};
    af_hit = '{4'd1, 4'd1, 4'd1, 4'd1};
`endif

    @(negedge clk);
    check("reset.rgb_valid", 32'(mix.rgb_valid), 32'd0);
    check("reset.rgb", 32'(mix.rgb), 32'd0);
    check("reset.hit", 32'(mix.hit_layer), 32'd15);
    @(negedge clk);
    rst_n = 1'b1;

    lv = '{3'd0, 3'd0, 3'd2, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5};
    pixel("basic", 1'b0, 4'b0001, 4'd2);

    lv = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    pixel("nowin", 1'b0, 4'b0000, 4'd15);
    pal_write(3'd0, 4'b1010);
    pixel("nowin_pal0", 1'b0, 4'b1010, 4'd15);

    lv = '{3'd3, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    mix.layer_en = 8'b1111_1110;
    pixel("disabled", 1'b0, 4'b0100, 4'd1);
    mix.layer_en = '1;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        check($sformatf("b2b%0d.valid", i - 2), 32'(mix.rgb_valid), 32'd1);
        check($sformatf("b2b%0d.rgb", i - 2), 32'(mix.rgb), 32'(bb_rgb[i-2]));
        check($sformatf("b2b%0d.hit", i - 2), 32'(mix.hit_layer), 32'(bb_hit[i-2]));
      end
      if (i < 4) begin
        lv            = bb_lv[i];
        mix.pix_valid = 1'b1;
      end else begin
        mix.pix_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b.idle_valid", 32'(mix.rgb_valid), 32'd0);
    check("b2b.hold_rgb", 32'(mix.rgb), 32'b1101);

    // Palette write landing on the same edge that stage 2 reads it.
    lv = '{3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    @(negedge clk);
    mix.pix_valid = 1'b1;
    @(negedge clk);
    mix.pix_valid = 1'b0;
    mix.pal_we    = 1'b1;
    mix.pal_addr  = 3'd1;
    mix.pal_data  = 4'b1111;
    @(negedge clk);
    mix.pal_we = 1'b0;
    check("wr_race.rgb", 32'(mix.rgb), 32'b0011);
    check("wr_race.valid", 32'(mix.rgb_valid), 32'd1);
    pixel("wr_after", 1'b0, 4'b1111, 4'd0);

    // Reset with pixels in flight.
    lv = '{3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    @(negedge clk);
    mix.pix_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mix.pix_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("midrst.valid", 32'(mix.rgb_valid), 32'd0);
    check("midrst.rgb", 32'(mix.rgb), 32'd0);
    check("midrst.hit", 32'(mix.hit_layer), 32'd15);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("postrst.valid", 32'(mix.rgb_valid), 32'd0);
    lv = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    pixel("postrst.pal0", 1'b0, 4'b0000, 4'd15);
    lv = '{3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    pixel("postrst.pal1", 1'b0, 4'b0011, 4'd0);

    // Flash: the coincident pixel sees the old phase, the next one the new.
    mix.flash_mask = 8'b0000_0010;
    lv = '{3'd0, 3'd5, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
    pixel("flash.f0", 1'b0, 4'b1101, 4'd1);
    for (int f = 0; f < 4; f++) begin
      pixel($sformatf("flash.co%0d", f + 1), 1'b1, co_rgb[f], co_hit[f]);
      pixel($sformatf("flash.af%0d", f + 1), 1'b0, af_rgb[f], af_hit[f]);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/layer_mixer.md
LAYER_MIXER -- requirements
Module: layer_mixer

Interface
REQ-001 Parameter NUM_LAYERS, default 8: number of layer colour-index inputs, legal range 2..16.
REQ-002 Parameter IDX_W, default 3: colour-index width, legal range 2..5; palette depth is 2^IDX_W.
REQ-003 Parameter RGB_W, default 4: palette entry and output colour width, legal range 4..12.
REQ-004 Parameter FLASH_FRAMES, default 16: frames per flash half-period, legal range 1..255.
REQ-005 clk  input  1: single clock; every register updates on the rising edge.
REQ-006 rst_n  input  1: reset, asynchronous and active-low.
REQ-007 pix_valid  input  1: layer_idx carries a valid pixel this cycle.
REQ-008 layer_idx  input  NUM_LAYERS*IDX_W: packed layer indices; layer k occupies bits [k*IDX_W +: IDX_W]; layer 0 has the highest priority.
REQ-009 frame_start  input  1: one-cycle pulse at the start of each frame.
REQ-010 layer_en  input  NUM_LAYERS: per-layer enable; a disabled layer is treated as index 0.
REQ-011 flash_mask  input  NUM_LAYERS: layers subject to flash blanking.
REQ-012 pal_we  input  1: palette write strobe.
REQ-013 pal_addr  input  IDX_W: palette write address.
REQ-014 pal_data  input  RGB_W: palette write data.
REQ-015 rgb  output  RGB_W: composed pixel colour.
REQ-016 rgb_valid  output  1: rgb is valid this cycle.
REQ-017 hit_layer  output  4: winning layer number; 15 when no layer wins.

Function
REQ-018 Stage 1 (registered): the winner SHALL be the lowest-numbered layer k with layer_en[k]=1, a nonzero index, and not blanked; output is the winner's index, or index 0 with hit 15 when there is no winner.
REQ-019 Stage 2 (registered): rgb SHALL equal palette[stage-1 index], and hit_layer SHALL equal the stage-1 hit number.
REQ-020 Latency SHALL be exactly 2 cycles from pix_valid to rgb_valid; the valid bit SHALL pipeline alongside the data; there is no backpressure.
REQ-021 When pix_valid=0, rgb_valid SHALL be 0 in the corresponding output cycle, and rgb and hit_layer SHALL hold their previous values.
REQ-022 Palette SHALL be a register array of 2^IDX_W entries, each RGB_W wide.
REQ-023 A palette write SHALL take effect on the following edge; a stage-2 read of the same address in the write cycle SHALL return the old value.
REQ-024 A palette write SHALL be accepted in every cycle, regardless of pix_valid.
REQ-025 Palette entry 0 SHALL be writable; rgb for "no winner" SHALL be palette[0].
REQ-026 A pixel whose inputs change while it is in flight SHALL be unaffected; stages capture their inputs at each edge.

Reset
REQ-027 While rst_n=0: rgb=0, rgb_valid=0, hit_layer=15, all pipeline valid bits=0, flash counter=0, flash_phase=0.
REQ-028 Palette reset values for entries 0..7, zero-extended to RGB_W: 0000, 0011, 0001, 0111, 0100, 1101, 0110, 1011. Entries 8 and above SHALL reset to 0.
REQ-029 Reset asserted mid-frame SHALL discard in-flight pixels; the first rgb_valid after release SHALL occur 2 cycles after the first pix_valid.

Configuration
REQ-030 Macro MIXER_FLASH_EN.
- When defined: an 8-bit frame counter SHALL increment on each frame_start.
- On a frame_start where the counter equals FLASH_FRAMES-1, the counter SHALL wrap to 0 and flash_phase SHALL toggle.
- While flash_phase=1, layers with flash_mask[k]=1 SHALL be blanked.
- frame_start coincident with pix_valid: the phase change SHALL apply from the next cycle.
REQ-031 When MIXER_FLASH_EN is not defined: no counter or flash_phase registers exist, flash_mask and frame_start are ignored, and no layer is ever blanked.

Verification
REQ-032 After reset, default parameters, layer_idx with L0=0, L1=0, L2=2, others 5, all enabled, pix_valid for 1 cycle -> 2 cycles later rgb=0001, hit_layer=2, rgb_valid=1.
REQ-033 All layers index 0 -> rgb=0000, hit_layer=15. Then write pal_addr=0, pal_data=1010 and repeat -> rgb=1010.
REQ-034 L0=3, layer_en[0]=0, L1=4 -> rgb=0100, hit_layer=1. Back-to-back pix_valid for 4 cycles with varying inputs -> 4 consecutive correct outputs with latency 2.
REQ-035 Write pal_addr=1, pal_data=1111 in the same cycle that stage 2 reads index 1 -> that pixel gets 0011; the next pixel gets 1111.
REQ-036 MIXER_FLASH_EN defined, FLASH_FRAMES=2, flash_mask[1]=1, L1=5, L3=1:
- frame_starts 1..2 -> rgb=1101 (hit 1);
- after the 2nd frame_start -> rgb=0011 (hit 3);
- after the 4th frame_start -> rgb=1101 again.
REQ-037 rst_n pulsed low with 2 pixels in flight -> rgb_valid=0 immediately and stays 0 until 2 cycles after the next pix_valid; palette returns to defaults.
